// File: rtl/adder_latency_monitor_pkg.sv
// FSM encoding and default sizing shared by the adder latency monitor files.
// Holds no logic.
package adder_latency_monitor_pkg;

  localparam int DEF_N       = 32;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_LAT_W   = 8;
  localparam int DEF_ACC_W   = 48;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/adder_latency_monitor_sat_accum.sv
// Saturating W-bit accumulator with clear and add enable; the new value is visible one cycle after clr/add_en.
// No backpressure: an add is taken on every enabled cycle, and clear beats add.
module sat_accum #(
  parameter int W  = 48,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          add_en,
  input  logic [IW-1:0] add_val,
  output logic [W-1:0]  acc
);

  logic [W:0] sum;

  // One extra bit catches the carry out, which pins the total at all-ones.
  assign sum = {1'b0, acc} + (W+1)'(add_val);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/adder_latency_monitor.sv
// Drives one operand set to an adder under test and counts edges until {Cout,S} matches a+b+cin or TIMEOUT expires.
// Takes one operand set at a time (in_ready only in IDLE); holds each result until res_ready.
module adder_latency_monitor
  import adder_latency_monitor_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int LAT_W   = DEF_LAT_W,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             cin,
  output logic [N-1:0]     op_a,
  output logic [N-1:0]     op_b,
  output logic             op_cin,
  input  logic [N:0]       obs_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [LAT_W-1:0] res_lat,
  output logic             res_tmo,
  input  logic             clr_stats,
  output logic [ACC_W-1:0] total_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic [ACC_W-1:0] n_tests,
  output logic [ACC_W-1:0] n_timeouts
);

  localparam logic [LAT_W-1:0] TMO = LAT_W'(TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  logic [N:0]       exp_sum;
  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] cnt_inc;
  logic             hit;
  logic             in_hs;
  logic             res_hs;
  logic             stat_add;

  assign in_hs    = in_valid && in_ready;
  assign res_hs   = res_valid && res_ready;
  assign stat_add = res_hs && !clr_stats;
  assign cnt_inc  = cnt + LAT_W'(1);

  // An X or Z anywhere in obs_sum makes the equality unknown, which is not a hit.
  assign hit = ((obs_sum == exp_sum) === 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_WAIT;
      S_WAIT:   if (hit || cnt_inc == TMO) state_nxt = S_REPORT;
      S_REPORT: if (res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    res_valid = (state == S_REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_cin  <= 1'b0;
      exp_sum <= '0;
      cnt     <= '0;
      res_lat <= '0;
      res_tmo <= 1'b0;
    end else begin
      if (in_hs) begin
        op_a    <= a;
        op_b    <= b;
        op_cin  <= cin;
        exp_sum <= {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        cnt     <= '0;
      end
      // A hit on the final edge is still reported as a match.
      if (state == S_WAIT) begin
        cnt <= cnt_inc;
        if (hit) begin
          res_lat <= cnt_inc;
          res_tmo <= 1'b0;
        end else if (cnt_inc == TMO) begin
          res_lat <= TMO;
          res_tmo <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      max_lat <= '0;
    end else if (stat_add && res_lat > max_lat) begin
      max_lat <= res_lat;
    end
  end

  sat_accum #(.W(ACC_W), .IW(LAT_W)) u_total_lat (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_stats),
    .add_en  (stat_add),
    .add_val (res_lat),
    .acc     (total_lat)
  );

  sat_accum #(.W(ACC_W), .IW(1)) u_n_tests (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_stats),
    .add_en  (stat_add),
    .add_val (1'b1),
    .acc     (n_tests)
  );

  sat_accum #(.W(ACC_W), .IW(1)) u_n_timeouts (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_stats),
    .add_en  (stat_add && res_tmo),
    .add_val (1'b1),
    .acc     (n_timeouts)
  );

endmodule

// File: tb/tb_adder_latency_monitor.sv
// Bench for adder_latency_monitor: a 32-bit instance watching a variable-delay registered adder,
// and an 8-bit instance (ACC_W=8) watching a combinational, registered or stuck-at-zero adder.
module tb_adder_latency_monitor;

  typedef struct packed {
    logic [7:0] lat;
    logic       tmo;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         mode;
    logic [7:0] lat;
    logic       tmo;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  exp_t sb32[$];
  exp_t sb8[$];

  // 32-bit instance signals
  logic        rst = 1'b0, in_valid = 1'b0, in_ready, cin = 1'b0, op_cin;
  logic [31:0] a = '0, b = '0, op_a, op_b;
  logic [32:0] obs32;
  logic        res_valid, res_ready = 1'b0, res_tmo, clr_stats = 1'b0;
  logic [7:0]  res_lat, max_lat;
  logic [47:0] total_lat, n_tests, n_timeouts;
  logic        tie0 = 1'b0;

  // 8-bit instance signals
  logic        rst8 = 1'b0, in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, op_cin8;
  logic [7:0]  a8 = '0, b8 = '0, op_a8, op_b8;
  logic [8:0]  obs8;
  logic        res_valid8, res_ready8 = 1'b0, res_tmo8, clr_stats8 = 1'b0;
  logic [7:0]  res_lat8, max_lat8, total_lat8, n_tests8, n_timeouts8;
  int          mode8 = 0;

  adder_latency_monitor #(.N(32), .TIMEOUT(64), .LAT_W(8), .ACC_W(48)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .obs_sum(obs32), .res_valid(res_valid), .res_ready(res_ready),
    .res_lat(res_lat), .res_tmo(res_tmo), .clr_stats(clr_stats),
    .total_lat(total_lat), .max_lat(max_lat), .n_tests(n_tests), .n_timeouts(n_timeouts)
  );

  adder_latency_monitor #(.N(8), .TIMEOUT(64), .LAT_W(8), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .op_a(op_a8), .op_b(op_b8), .op_cin(op_cin8),
    .obs_sum(obs8), .res_valid(res_valid8), .res_ready(res_ready8),
    .res_lat(res_lat8), .res_tmo(res_tmo8), .clr_stats(clr_stats8),
    .total_lat(total_lat8), .max_lat(max_lat8), .n_tests(n_tests8), .n_timeouts(n_timeouts8)
  );

  // Longest carry chain; the modelled dynamic adder settles in chain/4 edges.
  function automatic int chain_len(input logic [31:0] x, input logic [31:0] y, input logic c);
    int run;
    int best;
    run  = c ? 1 : 0;
    best = run;
    for (int i = 0; i < 32; i++) begin
      if (x[i] & y[i]) run = 1;
      else if ((x[i] ^ y[i]) && run > 0) run = run + 1;
      else run = 0;
      if (run > best) best = run;
    end
    return best;
  endfunction

  // Dynamic adder plus output register driving the 32-bit instance
  logic [32:0] true32, c_sum32, reg32;
  int          settle_cnt, settle_need;
  assign true32      = {1'b0, op_a} + {1'b0, op_b} + {32'b0, op_cin};
  assign settle_need = chain_len(op_a, op_b, op_cin) / 4;
  assign c_sum32     = (settle_cnt >= settle_need) ? true32 : ~true32;
  assign obs32       = tie0 ? '0 : reg32;
  always_ff @(posedge clk) begin
    if (rst || (in_valid && in_ready)) settle_cnt <= 0;
    else if (settle_cnt < 1000) settle_cnt <= settle_cnt + 1;
    reg32 <= c_sum32;
  end

  // 8-bit adder: mode 0 combinational, 1 registered, 2 stuck at zero
  logic [8:0] comb8, reg8;
  assign comb8 = {1'b0, op_a8} + {1'b0, op_b8} + {8'b0, op_cin8};
  assign obs8  = (mode8 == 0) ? comb8 : (mode8 == 1) ? reg8 : 9'd0;
  always_ff @(posedge clk) reg8 <= comb8;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic start32(input logic [31:0] va, input logic [31:0] vb, input logic vc, input exp_t e);
    int guard = 0;
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    check("in_ready32", in_ready, 1);
    sb32.push_back(e);
    in_valid = 1'b1; a = va; b = vb; cin = vc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res32(output int edges);
    exp_t got;
    edges = 0;
    do begin @(negedge clk); edges++; end while (!res_valid && edges < 200);
    check("res_valid32", res_valid, 1);
    got = sb32.pop_front();
    check("res_lat32", res_lat, got.lat);
    check("res_tmo32", res_tmo, got.tmo);
    check("lat_vs_edges32", res_lat, edges);
  endtask

  task automatic take32();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc, input exp_t e);
    exp_t got;
    int guard = 0;
    int edges = 0;
    while (!in_ready8 && guard < 200) begin @(negedge clk); guard++; end
    check("in_ready8", in_ready8, 1);
    sb8.push_back(e);
    in_valid8 = 1'b1; a8 = va; b8 = vb; cin8 = vc;
    @(negedge clk);
    in_valid8 = 1'b0;
    do begin @(negedge clk); edges++; end while (!res_valid8 && edges < 200);
    check("res_valid8", res_valid8, 1);
    got = sb8.pop_front();
    check("res_lat8", res_lat8, got.lat);
    check("res_tmo8", res_tmo8, got.tmo);
    res_ready8 = 1'b1;
    @(negedge clk);
    res_ready8 = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[7];
    exp_t        e;
    int          edges;
    int          bench_total;
    int          bench_max;
    int          hold_lat;
    logic [31:0] ra, rb, hold_a;
    logic        rc;
    bit          saw;

    tbl[0] = '{8'hFF, 8'h01, 1'b1, 0, 8'd1,  1'b0};
    tbl[1] = '{8'h00, 8'h00, 1'b0, 2, 8'd1,  1'b0};
    tbl[2] = '{8'h12, 8'h34, 1'b0, 1, 8'd2,  1'b0};
    tbl[3] = '{8'h80, 8'h80, 1'b1, 1, 8'd2,  1'b0};
    tbl[4] = '{8'h01, 8'h00, 1'b0, 2, 8'd64, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 0, 8'd1,  1'b0};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 1, 8'd2,  1'b0};

    // Reset state
    rst = 1'b1; rst8 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_total", total_lat, 0);
    check("rst_max", max_lat, 0);
    check("rst_tests", n_tests, 0);
    check("rst_tmos", n_timeouts, 0);
    check("rst_op_a", op_a, 0);
    check("rst8_in_ready", in_ready8, 1);
    check("rst8_tests", n_tests8, 0);

    // Table of 8-bit vectors across adder styles
    for (int i = 0; i < 7; i++) begin
      mode8 = tbl[i].mode;
      e.lat = tbl[i].lat;
      e.tmo = tbl[i].tmo;
      run8(tbl[i].a, tbl[i].b, tbl[i].cin, e);
      if (i == 0) check("tests8_first", n_tests8, 1);
    end
    check("tbl_total8", total_lat8, 73);
    check("tbl_tests8", n_tests8, 7);
    check("tbl_tmos8", n_timeouts8, 1);
    check("tbl_max8", max_lat8, 64);

    // Random vectors through the dynamic adder
    bench_total = 0;
    bench_max   = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      e.lat = 8'(chain_len(ra, rb, rc) / 4 + 2);
      e.tmo = 1'b0;
      start32(ra, rb, rc, e);
      wait_res32(edges);
      take32();
      bench_total += edges;
      if (edges > bench_max) bench_max = edges;
    end
    check("rand_total", total_lat, 48'(bench_total));
    check("rand_max", max_lat, 8'(bench_max));
    check("rand_tests", n_tests, 1000);
    check("rand_tmos", n_timeouts, 0);

    // Timeout with the adder output stuck at zero
    tie0 = 1'b1;
    e.lat = 8'd64; e.tmo = 1'b1;
    start32(32'd1, 32'd0, 1'b0, e);
    wait_res32(edges);
    take32();
    tie0 = 1'b0;
    check("tmo_count", n_timeouts, 1);
    check("tmo_tests", n_tests, 1001);
    check("tmo_total", total_lat, 48'(bench_total + 64));
    check("tmo_max", max_lat, 64);

    // Consumer stall, new offer ignored, then clear coinciding with the handshake
    hold_a = 32'h0000_F00F;
    e.lat = 8'(chain_len(hold_a, 32'h1, 1'b0) / 4 + 2); e.tmo = 1'b0;
    start32(hold_a, 32'h1, 1'b0, e);
    wait_res32(edges);
    hold_lat = int'(res_lat);
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1; cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", res_valid, 1);
      check("stall_lat", res_lat, 8'(hold_lat));
      check("stall_in_ready", in_ready, 0);
      check("stall_op_a", op_a, hold_a);
    end
    in_valid = 1'b0;
    clr_stats = 1'b1;
    take32();
    clr_stats = 1'b0;
    check("clr_tests", n_tests, 0);
    check("clr_total", total_lat, 0);
    check("clr_max", max_lat, 0);
    check("clr_tmos", n_timeouts, 0);
    check("clr_idle", in_ready, 1);
    check("clr_no_restart", res_valid, 0);

    // Counting resumes after the clear
    e.lat = 8'(chain_len(32'h7, 32'h9, 1'b1) / 4 + 2); e.tmo = 1'b0;
    start32(32'h7, 32'h9, 1'b1, e);
    wait_res32(edges);
    take32();
    check("post_clr_tests", n_tests, 1);

    // Reset in the middle of WAIT
    tie0 = 1'b1;
    in_valid = 1'b1; a = 32'd5; b = 32'd0; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_wait_busy", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_idle", in_ready, 1);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_tests", n_tests, 0);
    check("mid_rst_total", total_lat, 0);
    check("mid_rst_op_a", op_a, 0);
    saw = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (res_valid) saw = 1'b1;
    end
    check("mid_rst_no_result", saw, 0);
    tie0 = 1'b0;

    // Saturation of the 8-bit total
    clr_stats8 = 1'b1;
    @(negedge clk);
    clr_stats8 = 1'b0;
    check("sat_clr_total8", total_lat8, 0);
    mode8 = 1;
    e.lat = 8'd2; e.tmo = 1'b0;
    for (int i = 0; i < 200; i++) begin
      run8(8'(i), 8'd0, 1'b0, e);
      if (i == 126) check("sat_pre_total8", total_lat8, 254);
    end
    check("sat_total8", total_lat8, 255);
    check("sat_tests8", n_tests8, 200);
    check("sat_max8", max_lat8, 2);
    check("sat_tmos8", n_timeouts8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
